// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - pong match sequencer: serve timing, scoring, win detection
module pong_match_ctrl #(
  parameter int SCORE_LIMIT  = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_vsync,
  input  logic       i_game_start,
  input  logic       i_miss_p1,
  input  logic       i_miss_p2,
  output logic       o_ball_enable,
  output logic       o_ball_reset,
  output logic       o_serve_dir,
  output logic [3:0] o_score_p1,
  output logic [3:0] o_score_p2,
  output logic [1:0] o_state,
  output logic [1:0] o_winner
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [4:0] LIMIT     = 5'(SCORE_LIMIT);
  localparam logic [8:0] SERVE_LIM = 9'(SERVE_FRAMES);

  logic [1:0] state, state_n;
  logic [3:0] score_p1, score_p1_n;
  logic [3:0] score_p2, score_p2_n;
  logic [1:0] winner, winner_n;
  logic       serve_dir, serve_dir_n;
  logic       ball_enable, ball_enable_n;
  logic       ball_reset, ball_reset_n;
  logic [7:0] frame_cnt, frame_cnt_n;

  logic       vsync_q;
  logic       start_q;
  logic       vsync_rise;
  logic       start_rise;
  logic [8:0] frame_inc;
  logic [4:0] p1_inc;
  logic [4:0] p2_inc;

  // Inputs already live in the i_clk domain, so a single history flop per edge is enough
  assign vsync_rise = i_vsync & ~vsync_q;
  assign start_rise = i_game_start & ~start_q;

  // Widened increments so the limit compares cannot overflow
  assign frame_inc = {1'b0, frame_cnt} + 9'd1;
  assign p1_inc    = {1'b0, score_p1} + 5'd1;
  assign p2_inc    = {1'b0, score_p2} + 5'd1;

  // Next-state and next-output decode; every output is the registered copy of these
  always_comb begin
    state_n      = state;
    score_p1_n   = score_p1;
    score_p2_n   = score_p2;
    winner_n     = winner;
    serve_dir_n  = serve_dir;
    frame_cnt_n  = frame_cnt;
    ball_reset_n = 1'b0;

    case (state)
      ST_IDLE, ST_OVER: begin
        // Leaving IDLE or OVER always starts a fresh match served toward P2
        if (start_rise) begin
          state_n      = ST_SERVE;
          score_p1_n   = 4'd0;
          score_p2_n   = 4'd0;
          winner_n     = 2'b00;
          serve_dir_n  = 1'b1;
          frame_cnt_n  = 8'd0;
          ball_reset_n = 1'b1;
        end
      end

      ST_SERVE: begin
        if (vsync_rise) begin
          frame_cnt_n = frame_inc[7:0];
          if (frame_inc == SERVE_LIM) begin
            state_n = ST_PLAY;
          end
        end
      end

      ST_PLAY: begin
        if (i_miss_p1 && i_miss_p2) begin
          // Both edges missed at once: nobody scores, the other side serves
          serve_dir_n  = ~serve_dir;
          state_n      = ST_SERVE;
          frame_cnt_n  = 8'd0;
          ball_reset_n = 1'b1;
        end else if (i_miss_p2) begin
          serve_dir_n = 1'b1;
          if (p1_inc >= LIMIT) begin
            // Saturate at the limit; the ball stays where it is for the final screen
            score_p1_n = LIMIT[3:0];
            winner_n   = 2'b01;
            state_n    = ST_OVER;
          end else begin
            score_p1_n   = p1_inc[3:0];
            state_n      = ST_SERVE;
            frame_cnt_n  = 8'd0;
            ball_reset_n = 1'b1;
          end
        end else if (i_miss_p1) begin
          serve_dir_n = 1'b0;
          if (p2_inc >= LIMIT) begin
            score_p2_n = LIMIT[3:0];
            winner_n   = 2'b10;
            state_n    = ST_OVER;
          end else begin
            score_p2_n   = p2_inc[3:0];
            state_n      = ST_SERVE;
            frame_cnt_n  = 8'd0;
            ball_reset_n = 1'b1;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    ball_enable_n = (state_n == ST_PLAY);
  end

  // Match state registers; start history resets high so a held button cannot start a match
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      score_p1    <= 4'd0;
      score_p2    <= 4'd0;
      winner      <= 2'b00;
      serve_dir   <= 1'b1;
      ball_enable <= 1'b0;
      ball_reset  <= 1'b0;
      frame_cnt   <= 8'd0;
      vsync_q     <= 1'b0;
      start_q     <= 1'b1;
    end else begin
      state       <= state_n;
      score_p1    <= score_p1_n;
      score_p2    <= score_p2_n;
      winner      <= winner_n;
      serve_dir   <= serve_dir_n;
      ball_enable <= ball_enable_n;
      ball_reset  <= ball_reset_n;
      frame_cnt   <= frame_cnt_n;
      vsync_q     <= i_vsync;
      start_q     <= i_game_start;
    end
  end

  assign o_state       = state;
  assign o_score_p1    = score_p1;
  assign o_score_p2    = score_p2;
  assign o_winner      = winner;
  assign o_serve_dir   = serve_dir;
  assign o_ball_enable = ball_enable;
  assign o_ball_reset  = ball_reset;

endmodule
